boot_loader: RTL and testbench

Upstream loader for the processor core: receives a program as a byte stream over a valid/ready handshake, packs bytes into 16-bit instruction halfwords, and writes them into program memory through a single write port. On a verified load it raises `o_run`, which releases the core to start fetching at the load base. This is the first step toward replacing the fixed ROM with a loadable memory.

---
 rtl/boot_loader.sv | 129 ++++++++++++
 tb/tb_boot_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Byte-stream program loader: parses a length header, packs payload bytes into
// little-endian halfwords, writes them to program memory and verifies an XOR checksum.
module boot_loader #(
    parameter int          ADDR_W = 10,
    parameter logic [31:0] BASE   = 32'h0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [7:0]        i_data,
    output logic              o_ready,
    output logic              o_we,
    output logic [31:0]       o_addr,
    output logic [15:0]       o_wdata,
    output logic [ADDR_W:0]   o_count,
    output logic              o_run,
    output logic              o_err
);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DLO,
        S_DHI,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    // Largest accepted halfword count, widened so 2^16 programs still compare correctly.
    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    state_t           state;
    logic [7:0]       len_lo;
    logic [15:0]      len;
    logic [7:0]       lo_byte;
    logic [7:0]       csum;
    logic [ADDR_W:0]  count;
    logic [ADDR_W:0]  count_inc;
    logic [15:0]      hdr_len;
    logic             take;
    logic             last_hw;

    logic             ready_reg;
    logic             we_reg;
    logic [31:0]      addr_reg;
    logic [15:0]      wdata_reg;
    logic             run_reg;
    logic             err_reg;

    assign take      = i_valid && ready_reg;
    assign count_inc = count + 1'b1;
    assign hdr_len   = {i_data, len_lo};
    assign last_hw   = (32'(count_inc) == 32'(len));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_LEN_LO;
            len_lo    <= 8'h00;
            len       <= 16'h0000;
            lo_byte   <= 8'h00;
            csum      <= 8'h00;
            count     <= '0;
            ready_reg <= 1'b1;
            we_reg    <= 1'b0;
            addr_reg  <= 32'h0;
            wdata_reg <= 16'h0000;
            run_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            we_reg <= 1'b0;
            if (take) begin
                case (state)
                    S_LEN_LO: begin
                        len_lo <= i_data;
                        state  <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        len <= hdr_len;
                        if ({1'b0, hdr_len} > CAP) begin
                            state     <= S_ERR;
                            err_reg   <= 1'b1;
                            ready_reg <= 1'b0;
                        end else if (hdr_len == 16'h0000) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DLO;
                        end
                    end
                    S_DLO: begin
                        lo_byte <= i_data;
                        csum    <= csum ^ i_data;
                        state   <= S_DHI;
                    end
                    S_DHI: begin
                        // Address uses the pre-increment count: halfword k lands at BASE + 2k.
                        csum      <= csum ^ i_data;
                        we_reg    <= 1'b1;
                        addr_reg  <= BASE + (32'(count) << 1);
                        wdata_reg <= {i_data, lo_byte};
                        count     <= count_inc;
                        state     <= last_hw ? S_CSUM : S_DLO;
                    end
                    S_CSUM: begin
                        ready_reg <= 1'b0;
                        if (i_data == csum) begin
                            state   <= S_DONE;
                            run_reg <= 1'b1;
                        end else begin
                            state   <= S_ERR;
                            err_reg <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_ready = ready_reg;
    assign o_we    = we_reg;
    assign o_addr  = addr_reg;
    assign o_wdata = wdata_reg;
    assign o_count = count;
    assign o_run   = run_reg;
    assign o_err   = err_reg;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: two instances (BASE 0 and BASE 0x100) share one
// stimulus stream; a table of streams plus hand sequences for reset and capacity.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [7:0]  data;

    logic        ready0, we0, run0, err0;
    logic [31:0] addr0;
    logic [15:0] wdata0;
    logic [10:0] count0;
    logic        ready1, we1, run1, err1;
    logic [31:0] addr1;
    logic [15:0] wdata1;
    logic [10:0] count1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    boot_loader #(.ADDR_W(10), .BASE(32'h0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data),
        .o_ready(ready0), .o_we(we0), .o_addr(addr0), .o_wdata(wdata0),
        .o_count(count0), .o_run(run0), .o_err(err0)
    );

    boot_loader #(.ADDR_W(10), .BASE(32'h100)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data),
        .o_ready(ready1), .o_we(we1), .o_addr(addr1), .o_wdata(wdata1),
        .o_count(count1), .o_run(run1), .o_err(err1)
    );

    logic [31:0] wa0[$];
    logic [31:0] wa1[$];
    logic [15:0] wd0[$];
    logic [15:0] wd1[$];

    always @(negedge clk) begin
        if (we0) begin
            wa0.push_back(addr0);
            wd0.push_back(wdata0);
        end
        if (we1) begin
            wa1.push_back(addr1);
            wd1.push_back(wdata1);
        end
    end

    typedef struct {
        int          n;
        logic [63:0] b;
        int          bub;
        int          nw;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        run;
        logic        err;
        int          cnt;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic clear_q();
        wa0.delete(); wa1.delete(); wd0.delete(); wd1.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " ready0"}, 32'(ready0), 32'd1);
        chk({tag, " ready1"}, 32'(ready1), 32'd1);
        chk({tag, " we"},     32'({we0, we1}), 32'd0);
        chk({tag, " addr0"},  addr0, 32'h0);
        chk({tag, " addr1"},  addr1, 32'h0);
        chk({tag, " wdata"},  32'({wdata0, wdata1}), 32'h0);
        chk({tag, " count"},  32'({count0, count1}), 32'h0);
        chk({tag, " runerr"}, 32'({run0, run1, err0, err1}), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid = 1'b0;
        rst   = 1'b1;
        #1;
        chk_reset("rst_imm");
        @(posedge clk);
        #1;
        chk_reset("rst_held");
        @(negedge clk);
        rst = 1'b0;
        clear_q();
    endtask

    // Presents one byte for exactly one rising edge after `gap` idle cycles; data is
    // scrambled while valid is low so an ignored byte would corrupt results.
    task automatic send(input logic [7:0] b, input int gap);
        valid = 1'b0;
        data  = ~b;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        valid = 1'b1;
        data  = b;
        @(posedge clk);
        #1;
        valid = 1'b0;
        data  = 8'hA5 ^ b;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int gap;
        logic [15:0] ed;
        for (int j = 0; j < v.n; j++) begin
            gap = (v.bub == 1) ? 1 : (v.bub == 2) ? int'($urandom_range(0, 3)) : 0;
            if (j == v.n - 1)
                chk({tag, " pre_last run/err"}, 32'({run0, err0, run1, err1}), 32'h0);
            send(v.b[8*j +: 8], gap);
        end
        chk({tag, " run0"}, 32'(run0), 32'(v.run));
        chk({tag, " err0"}, 32'(err0), 32'(v.err));
        chk({tag, " run1"}, 32'(run1), 32'(v.run));
        chk({tag, " err1"}, 32'(err1), 32'(v.err));
        chk({tag, " ready_after"}, 32'({ready0, ready1}), 32'h0);
        if (v.err) begin
            send(8'h77, 0);
            send(8'h00, 0);
            chk({tag, " err_sticky"}, 32'({err0, err1, run0, run1}), 32'b1100);
        end
        repeat (2) @(posedge clk);
        #1;
        chk({tag, " count0"}, 32'(count0), 32'(v.cnt));
        chk({tag, " count1"}, 32'(count1), 32'(v.cnt));
        chk({tag, " nwrites0"}, 32'(wd0.size()), 32'(v.nw));
        chk({tag, " nwrites1"}, 32'(wd1.size()), 32'(v.nw));
        for (int k = 0; k < v.nw; k++) begin
            ed = (k == 0) ? v.d0 : v.d1;
            if (k < wd0.size()) begin
                chk($sformatf("%s wdata0[%0d]", tag, k), 32'(wd0[k]), 32'(ed));
                chk($sformatf("%s addr0[%0d]", tag, k), wa0[k], 32'(2 * k));
            end
            if (k < wd1.size()) begin
                chk($sformatf("%s wdata1[%0d]", tag, k), 32'(wd1[k]), 32'(ed));
                chk($sformatf("%s addr1[%0d]", tag, k), wa1[k], 32'h100 + 32'(2 * k));
            end
        end
        $display("vector %s: writes=%0d count=%0d run=%0b err=%0b", tag, wd0.size(), count0, run0, err0);
    endtask

    initial begin
        logic [7:0] x;
        logic [15:0] hw;

        // {n, bytes (byte0 in LSBs), bubble mode, writes, data0, data1, run, err, count}
        vecs[0] = '{7, 64'h0040ABCD12340002, 0, 2, 16'h1234, 16'hABCD, 1'b1, 1'b0, 2};
        vecs[1] = '{3, 64'h0000000000000000, 0, 0, 16'h0000, 16'h0000, 1'b1, 1'b0, 0};
        vecs[2] = '{5, 64'h000000FF22110001, 0, 1, 16'h2211, 16'h0000, 1'b0, 1'b1, 1};
        vecs[3] = '{2, 64'h0000000000000401, 0, 0, 16'h0000, 16'h0000, 1'b0, 1'b1, 0};
        vecs[4] = '{7, 64'h0040ABCD12340002, 1, 2, 16'h1234, 16'hABCD, 1'b1, 1'b0, 2};
        vecs[5] = '{7, 64'h0040ABCD12340002, 2, 2, 16'h1234, 16'hABCD, 1'b1, 1'b0, 2};
        vecs[6] = '{5, 64'h000000FF55AA0001, 0, 1, 16'h55AA, 16'h0000, 1'b1, 1'b0, 1};

        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;

        for (int i = 0; i < 7; i++) begin
            do_reset();
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset after a partial payload: next byte must restart as LEN_LO.
        do_reset();
        send(8'h02, 0);
        send(8'h00, 0);
        send(8'h34, 0);
        rst = 1'b1;
        #1;
        chk_reset("midrst_imm");
        @(posedge clk);
        #1;
        chk_reset("midrst_held");
        @(negedge clk);
        rst = 1'b0;
        clear_q();
        run_vec(vecs[0], "midrst");

        // Full-capacity program: N = 1024, halfword k = k.
        do_reset();
        send(8'h00, 0);
        send(8'h04, 0);
        x = 8'h00;
        for (int k = 0; k < 1024; k++) begin
            hw = 16'(k);
            x  = x ^ hw[7:0] ^ hw[15:8];
            send(hw[7:0], 0);
            send(hw[15:8], 0);
        end
        chk("cap pre_run", 32'({run0, err0}), 32'h0);
        send(x, 0);
        chk("cap run", 32'({run0, err0, run1, err1}), 32'b1010);
        repeat (2) @(posedge clk);
        #1;
        chk("cap count0", 32'(count0), 32'd1024);
        chk("cap nwrites", 32'(wd0.size()), 32'd1024);
        chk("cap addr_hold0", addr0, 32'd2046);
        chk("cap addr_hold1", addr1, 32'h100 + 32'd2046);
        chk("cap wdata_hold", 32'(wdata0), 32'h03FF);
        if (wd0.size() == 1024) begin
            chk("cap wdata0[512]", 32'(wd0[512]), 32'h0200);
            chk("cap addr0[512]", wa0[512], 32'd1024);
        end
        $display("vector capacity: writes=%0d count=%0d run=%0b err=%0b", wd0.size(), count0, run0, err0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
